// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer definitions used by the line writer and the read side.
//   - Screen geometry (H_RES x V_RES) and linear address width.
//   - Pixel/coordinate typedefs.
//   - Line-writer state enum.
//   - Small helpers for the 12-bit signed Bresenham datapath.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;  // 307200
  localparam int ADDR_W    = 19;

  // Width of the signed line-drawing datapath; wide enough for 2*err.
  localparam int CW = 12;

  typedef logic [3:0] color_t;
  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;
  typedef logic signed [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FRAME = 2'd3
  } wr_state_t;

  localparam coord_t ZERO_C = '0;
  localparam coord_t ONE_C  = coord_t'(1);
  localparam coord_t H_LIM  = coord_t'(H_RES);
  localparam coord_t V_LIM  = coord_t'(V_RES);

  function automatic coord_t abs_c(input coord_t v);
    return (v < ZERO_C) ? -v : v;
  endfunction

  // True when the pixel lands inside the visible area.
  function automatic logic on_screen(input coord_t x, input coord_t y);
    return (x >= ZERO_C) && (x < H_LIM) && (y >= ZERO_C) && (y < V_LIM);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// -----------------------------------------------------------------------------
// fb_addr_calc
// Combinational row/column to linear frame-buffer address: row*640 + col,
// built as (row<<9) + (row<<7) + col so no multiplier is needed.
// Ports:
//   i_row  [8:0]         pixel row
//   i_col  [9:0]         pixel column
//   o_addr [ADDR_W-1:0]  linear address
// -----------------------------------------------------------------------------
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [8:0]        i_row,
  input  logic [9:0]        i_col,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  // Widen first: even row 511 / col 1023 fit in 19 bits, so nothing wraps.
  assign w_row  = {{(ADDR_W-9){1'b0}}, i_row};
  assign w_col  = {{(ADDR_W-10){1'b0}}, i_col};
  assign o_addr = (w_row << 9) + (w_row << 7) + w_col;

endmodule

// File: rtl/fb_line_writer.sv
// -----------------------------------------------------------------------------
// fb_line_writer
// Producer side of the frame-buffer write port. Accepts line commands,
// rasterises them with Bresenham (one pixel per cycle) and pulses done on a
// frame-end command so the buffer controller can rotate its buffers.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_frame_end         1 = frame-end command (coordinates ignored)
//   x0,y0,x1,y1           line end points
//   cmd_color             line colour
//   w_addr                pixel address y*640+x (registered)
//   color_out             colour of the line being drawn
//   en_w                  pixel write strobe (registered)
//   done                  one-cycle end-of-frame pulse (registered)
//   busy                  writer not idle
// -----------------------------------------------------------------------------
module fb_line_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_frame_end,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        x1,
  input  logic [8:0]        y1,
  input  logic [3:0]        cmd_color,
  output logic [ADDR_W-1:0] w_addr,
  output logic [3:0]        color_out,
  output logic              en_w,
  output logic              done,
  output logic              busy
);

  wr_state_t r_state, w_state_next;

  coord_t r_cur_x, w_cur_x_next;
  coord_t r_cur_y, w_cur_y_next;
  coord_t r_end_x, w_end_x_next;
  coord_t r_end_y, w_end_y_next;
  coord_t r_dx,    w_dx_next;
  coord_t r_dy,    w_dy_next;
  coord_t r_sx,    w_sx_next;
  coord_t r_sy,    w_sy_next;
  coord_t r_err,   w_err_next;
  color_t r_color, w_color_next;

  logic              r_cmd_ready;
  logic              r_en_w;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_calc;

  logic              w_accept;
  logic              w_at_end;
  logic              w_step_x;
  logic              w_step_y;
  logic signed [CW:0] w_e2;
  logic signed [CW:0] w_dx_ext;
  logic signed [CW:0] w_dy_ext;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_at_end = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

  // Compare 2*err one bit wider so the doubling can never overflow.
  assign w_e2     = $signed({r_err, 1'b0});
  assign w_dx_ext = (CW+1)'(r_dx);
  assign w_dy_ext = (CW+1)'(r_dy);
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  always_comb begin
    w_state_next = r_state;
    w_cur_x_next = r_cur_x;
    w_cur_y_next = r_cur_y;
    w_end_x_next = r_end_x;
    w_end_y_next = r_end_y;
    w_dx_next    = r_dx;
    w_dy_next    = r_dy;
    w_sx_next    = r_sx;
    w_sy_next    = r_sy;
    w_err_next   = r_err;
    w_color_next = r_color;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_frame_end) begin
            w_state_next = ST_FRAME;
          end else begin
            w_cur_x_next = $signed({2'b00, x0});
            w_cur_y_next = $signed({3'b000, y0});
            w_end_x_next = $signed({2'b00, x1});
            w_end_y_next = $signed({3'b000, y1});
            w_color_next = cmd_color;
            w_state_next = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        w_dx_next    = abs_c(r_end_x - r_cur_x);
        w_dy_next    = -abs_c(r_end_y - r_cur_y);
        w_sx_next    = (r_cur_x < r_end_x) ? ONE_C : -ONE_C;
        w_sy_next    = (r_cur_y < r_end_y) ? ONE_C : -ONE_C;
        w_err_next   = w_dx_next + w_dy_next;
        w_state_next = ST_DRAW;
      end

      ST_DRAW: begin
        if (w_at_end) begin
          w_state_next = ST_IDLE;
        end else begin
          // A diagonal step applies both moves and both error terms.
          if (w_step_x) w_cur_x_next = r_cur_x + r_sx;
          if (w_step_y) w_cur_y_next = r_cur_y + r_sy;
          w_err_next = r_err + (w_step_x ? r_dy : ZERO_C)
                             + (w_step_y ? r_dx : ZERO_C);
        end
      end

      ST_FRAME: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address of the pixel that will be shown next cycle, so the strobe and
  // address come straight out of flops while the pixel is on the bus.
  fb_addr_calc u_addr_calc (
    .i_row  (w_cur_y_next[8:0]),
    .i_col  (w_cur_x_next[9:0]),
    .o_addr (w_addr_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_x     <= ZERO_C;
      r_cur_y     <= ZERO_C;
      r_end_x     <= ZERO_C;
      r_end_y     <= ZERO_C;
      r_dx        <= ZERO_C;
      r_dy        <= ZERO_C;
      r_sx        <= ZERO_C;
      r_sy        <= ZERO_C;
      r_err       <= ZERO_C;
      r_color     <= '0;
      r_cmd_ready <= 1'b0;
      r_en_w      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur_x     <= w_cur_x_next;
      r_cur_y     <= w_cur_y_next;
      r_end_x     <= w_end_x_next;
      r_end_y     <= w_end_y_next;
      r_dx        <= w_dx_next;
      r_dy        <= w_dy_next;
      r_sx        <= w_sx_next;
      r_sy        <= w_sy_next;
      r_err       <= w_err_next;
      r_color     <= w_color_next;
      r_cmd_ready <= (w_state_next == ST_IDLE);
      r_done      <= (w_state_next == ST_FRAME);
      // Off-screen pixels still take their DRAW cycle, just without a write.
      r_en_w      <= (w_state_next == ST_DRAW) && on_screen(w_cur_x_next, w_cur_y_next);
      if (w_state_next == ST_DRAW) begin
        r_addr <= w_addr_calc;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign w_addr    = r_addr;
  assign color_out = r_color;
  assign en_w      = r_en_w;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/fb_line_writer.md
Name: fb_line_writer

Overview:
- Producer end of the triple-buffered frame-buffer write port.
- Accepts line-draw commands from the vector engine, rasterises each line with Bresenham and emits one pixel write per cycle: linear address w_addr, colour and en_w.
- A frame-end command pulses done, which the frame-buffer controller edge-detects to rotate its read/write/clear buffers.

Parameters:
- H_RES, 640, visible columns; also the row stride of the linear address.
- V_RES, 480, visible rows.
- ADDR_W, 19, linear address width (covers H_RES*V_RES = 307200).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_frame_end  in  1  1 = end-of-frame command; coordinates ignored
- x0  in  10  start column
- y0  in  9  start row
- x1  in  10  end column
- y1  in  9  end row
- cmd_color  in  4  pixel colour
- w_addr  out  ADDR_W  pixel address, y*H_RES + x
- color_out  out  4  pixel colour
- en_w  out  1  pixel write strobe, one pixel per high cycle
- done  out  1  single-cycle end-of-frame pulse
- busy  out  1  line or frame-end in progress

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; all outputs 0 except cmd_ready (0 during the reset cycle, 1 the cycle after).
- States: IDLE, SETUP, DRAW, FRAME.
- IDLE: cmd_ready=1. On handshake with cmd_frame_end=1 -> FRAME. Otherwise latch coords and colour -> SETUP.
- SETUP, one cycle, all values sign-extended to 12 bits:
  - dx=|x1-x0|; dy=-|y1-y0|; sx=(x0<x1)?+1:-1; sy=(y0<y1)?+1:-1; err=dx+dy; cur=(x0,y0).
- DRAW, one pixel per cycle, outputs registered:
  - en_w=1 iff cur.x<H_RES && cur.y<V_RES (clipped pixels still consume a cycle).
  - w_addr = cur.y*H_RES + cur.x; color_out = latched colour.
  - If cur==(x1,y1): -> IDLE after this pixel.
  - Else: e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}. Both updates apply when both conditions hold; err accumulates both.
- Latency and count:
  - Accept at cycle N -> first en_w at N+2.
  - max(dx,|dy|)+1 DRAW cycles per line.
  - cmd_ready high again the cycle after the last pixel.
- Degenerate line (x0==x1, y0==y1): exactly one DRAW cycle.
- FRAME: done=1 for exactly one cycle (cycle N+1 after accept), en_w=0, then -> IDLE. Consecutive frame-end commands produce pulses at least 2 cycles apart, so every pulse is a clean rising edge.
- Ordering: all writes of earlier lines complete before done rises. Commands are never reordered or dropped.
- busy = (state != IDLE).
- Address arithmetic: implemented as (y<<9)+(y<<7)+x for H_RES=640; no multiplier. Result is always < 2^ADDR_W for clipped-in pixels.
- Reset mid-operation: any state -> IDLE next cycle; en_w=0 and done=0 immediately; the partially drawn line is abandoned; no done is emitted.
- cmd_valid while not ready: held off by the producer; no input is sampled.

Decomposition:
- Shared package fb_pkg:
  - H_RES, V_RES, FB_PIXELS=307200, ADDR_W.
  - typedef color_t (logic[3:0]), xcoord_t (logic[9:0]), ycoord_t (logic[8:0]).
  - Writer state enum.
- One sub-module, fb_addr_calc (row, col -> linear address, combinational shift-add), reused by the read side.

Test Plan:
- Line (0,0)->(3,0), colour 5, accepted cycle N -> en_w at N+2..N+5; w_addr 0,1,2,3; color_out 5; cmd_ready=1 at N+6.
- Diagonal (10,10)->(12,12) -> 3 writes, w_addr 6410, 7051, 7692.
- Steep reverse (5,4)->(4,0) -> 5 writes, pixels (5,4),(5,3),(4,2),(4,1),(4,0); w_addr 2565, 1925, 1284, 644, 4.
- Clip (638,0)->(641,0) -> 4 DRAW cycles; en_w only for w_addr 638, 639; en_w=0 for x=640, 641.
- Frame-end accepted at N -> done=1 only at N+1; en_w=0 throughout. Back-to-back frame-end commands -> two separate done pulses with done=0 between.
- rst asserted on the 10th pixel of (0,0)->(99,0) -> en_w=0 and done=0 next cycle; cmd_ready=1 the cycle after rst drops; no further writes.
